// File: rtl/cog_cap_if.sv
// cog_cap_if
//   Bus bundle between a cog and its pulse capture unit.
//   master : the cog side. It drives setcap/data/pin_in/ack and
//            observes cap/valid/ovf/lost/busy.
//   slave  : the capture unit, which is the mirror image of master.
//   Parameter CW is the counter/result width and must match the
//   width used by the attached cog_cap instance.
interface cog_cap_if #(
  parameter int unsigned CW = 32
);
  logic          setcap;
  logic [31:0]   data;
  logic [31:0]   pin_in;
  logic          ack;
  logic [CW-1:0] cap;
  logic          valid;
  logic          ovf;
  logic          lost;
  logic          busy;

  modport master (
    output setcap, data, pin_in, ack,
    input  cap, valid, ovf, lost, busy
  );

  modport slave (
    input  setcap, data, pin_in, ack,
    output cap, valid, ovf, lost, busy
  );
endinterface

// File: rtl/cog_cap.sv
// cog_cap
//   Per-cog pulse capture unit. It measures the period or the pulse width
//   of one selected pin in clk_cog ticks and latches the result for the
//   cog. A valid/ack handshake hands the result over, and sticky flags
//   report counter saturation (ovf) and overwritten results (lost).
//
//   Ports
//     clk_cog    : cog clock, the only clock
//     res        : synchronous active-high reset
//     bus.setcap : load control word from bus.data
//     bus.data   : [4:0] pin, [6:5] mode (01 period, 10 width, else off),
//                  [7] pol (1 = measure from falling edge), [8] cont
//     bus.pin_in : pin inputs, asynchronous to clk_cog
//     bus.ack    : cog consumed cap; clears valid
//     bus.cap    : latched measurement
//     bus.valid  : cap holds an unconsumed result
//     bus.ovf    : sticky, counter saturated during current measurement
//     bus.lost   : sticky, a result overwrote an unacked result
//     bus.busy   : a measurement is in progress
module cog_cap #(
  parameter int unsigned CW = 32
) (
  input  logic     clk_cog,
  input  logic     res,
  cog_cap_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ARM,
    ST_COUNT,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_PERIOD = 2'b01,
    MODE_WIDTH  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // Control word fields
  logic [4:0]    pin_sel;
  mode_t         mode;
  logic          pol;
  logic          cont;

  // Pin synchroniser and edge history
  logic          s1, s2, s3;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cap_q;
  logic          valid_q;
  logic          ovf_q;
  logic          lost_q;

  // Decoded control word being loaded
  mode_t         new_mode;
  logic          new_active;

  // Edge events and counter helpers
  logic          pin_now;
  logic          rise, fall;
  logic          start_ev, opp_ev, stop_ev;
  logic [CW-1:0] cnt_inc;
  logic          cnt_sat;

  // Upper control word bits are reserved.
  logic          unused_data;
  assign unused_data = ^bus.data[31:9];

  always_comb begin
    new_mode   = mode_t'(bus.data[6:5]);
    new_active = (new_mode == MODE_PERIOD) || (new_mode == MODE_WIDTH);
  end

  always_comb begin
    pin_now  = bus.pin_in[pin_sel];
    rise     = s2 & ~s3;
    fall     = ~s2 & s3;
    start_ev = pol ? fall : rise;
    opp_ev   = pol ? rise : fall;
    // Period mode closes on the next start edge, width mode on the
    // opposite edge. In width mode start and opposite can never fire
    // together because both come from the same s2/s3 pair.
    stop_ev  = (mode == MODE_PERIOD) ? start_ev : opp_ev;
    cnt_inc  = cnt + CW'(1);
    cnt_sat  = (cnt == '1);
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      pin_sel <= '0;
      mode    <= MODE_OFF;
      pol     <= 1'b0;
      cont    <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state   <= ST_OFF;
      cnt     <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else if (bus.setcap) begin
      pin_sel <= bus.data[4:0];
      mode    <= new_mode;
      pol     <= bus.data[7];
      cont    <= bus.data[8];
      // Flush the synchroniser so an edge seen on the old pin cannot
      // leak into the new configuration.
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      cnt     <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
      state   <= new_active ? ST_ARM : ST_OFF;
    end else begin
      s1 <= pin_now;
      s2 <= s1;
      s3 <= s2;

      // ack clears valid; a stop on the same edge overrides this below so
      // that the fresh result is never dropped.
      if (bus.ack) begin
        valid_q <= 1'b0;
      end

      case (state)
        ST_OFF: begin
        end

        ST_ARM: begin
          if (start_ev) begin
            cnt   <= CW'(1);
            state <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (stop_ev) begin
            cap_q   <= cnt;
            valid_q <= 1'b1;
            if (valid_q && !bus.ack) begin
              lost_q <= 1'b1;
            end
            if (cont && (mode == MODE_PERIOD)) begin
              // The stop edge is also the next start edge: restart at 1
              // so back-to-back periods have no gap.
              cnt   <= CW'(1);
              ovf_q <= 1'b0;
            end else if (cont) begin
              ovf_q <= 1'b0;
              state <= ST_ARM;
            end else begin
              state <= ST_HOLD;
            end
          end else if (!cnt_sat) begin
            cnt <= cnt_inc;
            if (cnt_inc == '1) begin
              ovf_q <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (bus.ack) begin
            ovf_q <= 1'b0;
            state <= ST_ARM;
          end
        end

        default: begin
          state <= ST_OFF;
        end
      endcase
    end
  end

  assign bus.cap   = cap_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.lost  = lost_q;
  assign bus.busy  = (state == ST_COUNT);

endmodule

// File: doc/cog_cap.md
Name: cog_cap

Overview:
- Per-cog pulse capture unit. It is the receive-side counterpart of the cog counter's NCO/duty/PLL pin generators.
- It measures the period or the pulse width of one selected pin, in clk_cog ticks.
- It latches the result for the cog, with a valid/ack handshake and sticky overflow and overrun flags.
- It sits beside the cog counters and takes the same pin_in bus and the same data/set-strobe style.

Parameters:
CW, 32, counter and result width in bits (benches may narrow it to exercise overflow)

Ports:
clk_cog  in  1  cog clock; the only clock
res  in  1  synchronous active-high reset
setcap  in  1  load control word from data
data  in  32  control word; [4:0]=pin, [6:5]=mode (00 off, 01 period, 10 width, 11 reserved=off), [7]=pol, [8]=cont
pin_in  in  32  pin inputs, asynchronous to clk_cog
ack  in  1  cog consumed cap; clears valid
cap  out  CW  latched measurement
valid  out  1  cap holds an unconsumed result
ovf  out  1  sticky: counter saturated during the current measurement
lost  out  1  sticky: a result overwrote an unacked result
busy  out  1  state==COUNT

Behaviour:
- Reset (res=1 at a clk_cog edge):
  - ctrl, cnt, cap, sync regs, valid, ovf, lost, busy all go to 0; state goes to OFF.
  - res beats every other input.
- Input path:
  - s1<=pin_in[pin], s2<=s1, s3<=s2.
  - rise = s2&!s3; fall = !s2&s3.
  - A pin transition sampled at edge t produces its event at edge t+2.
- Active edge:
  - pol=0: start edge = rise, opposite edge = fall.
  - pol=1: start edge = fall, opposite edge = rise.
- setcap (priority below res, above all else):
  - Loads ctrl and clears cnt, cap, valid, ovf and lost.
  - Clears s1..s3, so no stale edge is seen.
  - Next state is ARM if mode is 01 or 10, otherwise OFF.
- States:
  - OFF: idle, nothing counts.
  - ARM: on start edge, cnt<=1 and go to COUNT.
  - COUNT:
    - Each cycle cnt<=cnt+1, saturating at all-ones.
    - Entering saturation sets ovf.
    - Stop event: in period mode, the next start edge; in width mode, the opposite edge.
    - On stop, cap<=cnt and valid<=1.
    - If valid=1 and ack=0 on that cycle, lost<=1.
  - After a stop event:
    - cont=1 and period mode: cnt<=1, ovf<=0, stay in COUNT. The stop edge is the next start edge, so there are no gaps between measurements.
    - cont=1 and width mode: ovf<=0, go to ARM.
    - cont=0: go to HOLD.
  - HOLD: ignore the pin. On ack, go to ARM (re-arm single shot) and clear ovf.
- Result value:
  - Edges P cycles apart give cap=P.
  - Minimum is 1; a width shorter than 1 cycle is not resolved.
  - On saturation, cap = 2^CW-1 with ovf=1.
- Handshake:
  - ack clears valid on the same edge.
  - If ack and a new stop coincide, the new result wins: valid stays 1, lost is unchanged, cap takes the new value.
  - ack with valid=0 is ignored. In HOLD, ack always re-arms.
- Simultaneous events:
  - In width mode, start and opposite edges cannot coincide because of the single sync chain.
  - setcap during COUNT aborts the measurement; no partial result is latched.
- Outputs are all registered except busy, which decodes state.

Test Plan:
1. setcap data=0x0000_0023 (pin 3, period, pol=0, single). pin 3 is a square wave with period 10. Required: cap=10 and valid=1 four cycles after the second rising edge at the pin (2 sync + 1 latch + margin). State is HOLD and cap stays stable through further edges. ack re-arms and a fresh cap=10 follows.
2. data=0x0000_00DF (pin 31, width, pol=1). Drive a low pulse of 7 cycles. Required: cap=7, valid=1, ovf=0.
3. data=0x0000_0120 (pin 0, period, cont) with edges 5 and then 8 cycles apart, no ack. Required: first cap=5, then cap=8 with valid=1 and lost=1.
4. Same as test 3, but ack is asserted on exactly the cycle of the second stop. Required: valid stays 1, cap=8, lost=0. ack one cycle later drives valid to 0.
5. CW=8, period mode, one rising edge then no edge for 300 cycles, then a rising edge. Required: cap=255, ovf=1. setcap then clears both ovf and valid.
6. Two resets:
   - res mid-COUNT: next cycle all outputs are 0, state is OFF, and pin edges are ignored until setcap.
   - setcap mid-COUNT with a new pin: no result latched, and measurement restarts on the new pin's first start edge.
